// File: rtl/count_enable_ctrl_if.sv
// Button/strobe bundle between the run/stop control stage and its driver/observer.
// The slave modport is the control stage; the master side drives the button.
interface count_enable_ctrl_if;
  logic btn;
  logic e;
  logic running;
  logic btn_pulse;

  modport master (
    output btn,
    input  e,
    input  running,
    input  btn_pulse
  );

  modport slave (
    input  btn,
    output e,
    output running,
    output btn_pulse
  );
endinterface

// File: rtl/count_enable_ctrl.sv
// Run/stop control for count4: synchronises and debounces a pushbutton, toggles run state per press,
// and emits a one-cycle enable strobe every DIV clocks while running. Optional macro: COUNT_ENABLE_AUTOSTOP_EN.
module count_enable_ctrl #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned DB_CYCLES = 8,
  parameter int unsigned DB_W      = 8,
  parameter int unsigned MAX_TICKS = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  count_enable_ctrl_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [DB_W-1:0]  r_dcnt;
  logic [DIV_W-1:0] r_pcnt;
  logic             r_btn_pulse;
  run_state_t       r_state;
  run_state_t       w_state_next;

  logic w_settle;
  logic w_press;
  logic w_running;
  logic w_e;
  logic w_autostop;

  assign w_settle  = (r_sync2 != r_stable) && (r_dcnt == DB_W'(DB_CYCLES - 1));
  assign w_press   = w_settle && r_sync2;
  assign w_running = (r_state == ST_RUN);
  assign w_e       = w_running && (r_pcnt == DIV_W'(DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.btn;
      r_sync2 <= r_sync1;
    end
  end

  // Any sample matching the accepted level restarts the stability count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stable <= 1'b0;
      r_dcnt   <= '0;
    end else if (r_sync2 == r_stable) begin
      r_dcnt <= '0;
    end else if (w_settle) begin
      r_stable <= r_sync2;
      r_dcnt   <= '0;
    end else begin
      r_dcnt <= r_dcnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_btn_pulse <= 1'b0;
    end else begin
      r_btn_pulse <= w_press;
    end
  end

`ifdef COUNT_ENABLE_AUTOSTOP_EN
  localparam int unsigned TICK_W = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS + 1);

  logic [TICK_W-1:0] r_ticks;

  // The strobe that completes the budget stops the run on the edge that samples it.
  assign w_autostop = w_e && (r_ticks == TICK_W'(MAX_TICKS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ticks <= '0;
    end else if ((r_state == ST_IDLE) && (w_state_next == ST_RUN)) begin
      r_ticks <= '0;
    end else if (w_e) begin
      r_ticks <= r_ticks + 1'b1;
    end
  end
`else
  // Without the tick counter MAX_TICKS has no effect.
  assign w_autostop = 1'b0 & (MAX_TICKS == 0);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_press) w_state_next = ST_RUN;
      ST_RUN:  if (w_press || w_autostop) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Prescaler starts from zero on every run entry and is cleared on the stopping edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pcnt <= '0;
    end else if (w_state_next == ST_IDLE) begin
      r_pcnt <= '0;
    end else if (r_state == ST_RUN) begin
      if (r_pcnt == DIV_W'(DIV - 1)) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + 1'b1;
      end
    end else begin
      r_pcnt <= '0;
    end
  end

  assign bus.e         = w_e;
  assign bus.running   = w_running;
  assign bus.btn_pulse = r_btn_pulse;

endmodule

// File: tb/tb_count_enable_ctrl.sv
// Directed bench for count_enable_ctrl with DIV=4, DB_CYCLES=8, MAX_TICKS=15.
// Expectations follow the autostop macro when it is defined for the build.
module tb_count_enable_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] q4;

  always #5 clk = ~clk;

  count_enable_ctrl_if bus ();

  count_enable_ctrl #(
    .DIV       (4),
    .DIV_W     (8),
    .DB_CYCLES (8),
    .DB_W      (8),
    .MAX_TICKS (15)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // count4 stand-in: advances on each sampled enable strobe
  always @(posedge clk or posedge rst) begin
    if (rst) q4 <= 4'd0;
    else if (bus.e) q4 <= q4 + 4'd1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input int run_e, input int e_e, input int pulse_e);
    chk({tag, ".running"}, int'(bus.running), run_e);
    chk({tag, ".e"}, int'(bus.e), e_e);
    chk({tag, ".pulse"}, int'(bus.btn_pulse), pulse_e);
  endtask

  // First edge sampling the new high level is edge 1; the toggle lands on edge 10.
  task automatic expect_press(input string tag);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i < 10) chk_outs(tag, 0, 0, 0);
      else        chk_outs(tag, 1, 0, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_cnt;
    int rise_at;
    int run_x;

    // 1: reset, button pressed during reset, latency after release
    rst = 1'b1;
    bus.btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_outs("rst_btn0", 0, 0, 0);
    end
    bus.btn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_outs("rst_btn1", 0, 0, 0);
    end
    rst = 1'b0;
    expect_press("press1");

    // 2/3: strobe cadence, bounce, settle low, then second press lands with pcnt=2
    for (int k = 1; k <= 58; k++) begin
      if (k <= 8)       bus.btn = 1'b1;
      else if (k <= 38) bus.btn = (((k - 9) / 3) % 2 == 0) ? 1'b0 : 1'b1;
      else if (k <= 49) bus.btn = 1'b0;
      else              bus.btn = 1'b1;
      step();
      chk_outs("run1", 1, (k % 4 == 3) ? 1 : 0, 0);
    end

    // 4: stop mid-period; the strobe due this cycle is suppressed
    step();
    chk_outs("stop", 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      step();
      chk_outs("held", 0, 0, 0);
    end
    bus.btn = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk_outs("release", 0, 0, 0);
    end
    bus.btn = 1'b1;
    expect_press("press3");
    step();
    chk_outs("restart_o1", 1, 0, 0);
    step();
    chk_outs("restart_o2", 1, 0, 0);

    // 5: short asynchronous reset with pcnt=2
    bus.btn = 1'b0;
    #2 rst = 1'b1;
    #1 chk_outs("async_rst", 0, 0, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_outs("post_rst", 0, 0, 0);
    end

    // 6: long run from a fresh count4
    chk("q4_start", int'(q4), 0);
    bus.btn = 1'b1;
    rise_at = 0;
    for (int i = 1; i <= 20 && rise_at == 0; i++) begin
      step();
      if (bus.running) rise_at = i;
    end
    chk("rise_edge", rise_at, 10);
    e_cnt = 0;
    for (int o = 1; o <= 80; o++) begin
      if (o == 21) bus.btn = 1'b0;
      step();
`ifdef COUNT_ENABLE_AUTOSTOP_EN
      run_x = (o <= 59) ? 1 : 0;
`else
      run_x = 1;
`endif
      chk_outs("long", run_x, (run_x == 1 && o % 4 == 3) ? 1 : 0, 0);
      if (bus.e) e_cnt++;
    end
`ifdef COUNT_ENABLE_AUTOSTOP_EN
    chk("e_total", e_cnt, 15);
    chk("q4_end", int'(q4), 15);
`else
    chk("e_total", e_cnt, 20);
    chk("q4_end", int'(q4), 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
